phy_tx_arbiter: RTL and testbench
=================================

Name: phy_tx_arbiter

Overview:
- Packet-level round-robin arbiter sharing the single phy_tx_complexState AXI-stream input between two requesters.
  - Source 0: user data.
  - Source 1: link/control messages.
- Sits directly upstream of the PHY TX.
- Never interleaves beats of different packets.
- Enforces a maximum packet length, truncating and draining over-long packets.
- Holds off all grants until the GT TX reports done.

Parameters:
- P_DATA_W, 32, stream data width.
- P_KEEP_W, 4, byte-enable width (P_DATA_W/8).
- P_MAX_BEATS, 256, maximum beats per packet forwarded downstream.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_gt_tx_done  in  1  GT TX ready; new grants only while high.
- i_axi_s0_valid / i_axi_s1_valid  in  1  source valid.
- i_axi_s0_keep / i_axi_s1_keep  in  P_KEEP_W  source byte enables.
- i_axi_s0_data / i_axi_s1_data  in  P_DATA_W  source data.
- i_axi_s0_last / i_axi_s1_last  in  1  source end of packet.
- o_axi_s0_ready / o_axi_s1_ready  out  1  source ready.
- o_axi_m_valid  out  1  to PHY TX valid.
- o_axi_m_keep  out  P_KEEP_W  to PHY TX byte enables.
- o_axi_m_data  out  P_DATA_W  to PHY TX data.
- o_axi_m_last  out  1  to PHY TX end of packet.
- i_axi_m_ready  in  1  PHY TX ready.
- o_grant  out  2  one-hot current owner; 00 when idle.
- o_err_overlong  out  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Reset (async, i_rst=1): all outputs 0; state=IDLE; last-served pointer=1, so source 0 wins the first tie; beat counter 0.
- Output stage is a one-deep register.
  - It loads when (~o_axi_m_valid | i_axi_m_ready).
  - It clears valid when drained with no new load.
  - keep/data/last hold while valid & ~ready.
- Granted source ready = state==XFER & grant bit & (~o_axi_m_valid | i_axi_m_ready). The non-granted ready is always 0.
- IDLE:
  - Arbitration happens when i_gt_tx_done=1 and any valid.
  - If only one source is valid, that source wins.
  - If both are valid, the source not last served wins.
  - Grant registers and moves to XFER; this gives one bubble cycle. Ready is 0 while in IDLE.
- XFER:
  - Each accepted beat is copied to the output register and increments the beat counter.
  - Accepted beat with last=1: go to IDLE, update last-served, clear counter and o_grant.
  - Accepted beat number P_MAX_BEATS with last=0:
    - Output that beat with o_axi_m_last forced to 1.
    - Pulse o_err_overlong.
    - Go to DRAIN.
- DRAIN:
  - Granted ready=1 unconditionally; beats are discarded and not forwarded.
  - On an accepted beat with last=1, go to IDLE and update last-served.
- i_gt_tx_done falling mid-packet: current packet completes (XFER/DRAIN continue); no new grant until it is high again.
- Latency: first beat appears on o_axi_m_valid 2 cycles after source valid rises in IDLE, i.e. 1 arbitration cycle plus 1 register cycle. Throughput after that is 1 beat/cycle.
- Single-beat packet (valid & last on first beat): returns to IDLE the cycle after acceptance. Back-to-back packets from the same source therefore have a 1-cycle gap.
- Beat counter width is $clog2(P_MAX_BEATS+1) and it never wraps. A packet of exactly P_MAX_BEATS beats ending with last=1 is not an error.
- Sources must hold valid/data stable until ready. The arbiter does not check this.

Decomposition:
- Package phy_tx_arb_pkg holds:
  - state encoding: IDLE=2'd0, XFER=2'd1, DRAIN=2'd2;
  - source indices SRC_USER=0, SRC_CTRL=1;
  - the counter-width function.
- Sub-module phy_tx_axis_reg: the one-deep output register with valid/ready. The arbiter FSM, mux and counter stay in the top module.

Test Plan:
- Src0 sends a 3-beat packet (0x12345678 keep 1111; 0x87654321 keep 1111; 0x98765432 keep 1000 last), m_ready=1 → same 3 beats in order on the output, last on the third beat, first output beat 2 cycles after valid, o_grant=01 during the packet.
- Src0 and src1 both assert 2-beat packets continuously → packets alternate s0, s1, s0, s1; no interleave; 1-cycle gap between packets.
- P_MAX_BEATS=4, src1 sends 6 beats 0x1..0x6 → output 0x1..0x4 with last on 0x4; o_err_overlong pulses once; 0x5 and 0x6 are accepted but not output; arbiter returns to IDLE.
- m_ready toggles 1,0,1,0 during a 4-beat packet → no beats lost or duplicated; output held stable while ready=0; source ready=0 whenever the output register is full and blocked.
- i_gt_tx_done=0 with src0 valid → no grant, ready=0. Then done=1 → grant the next cycle. Done dropped mid-packet → packet completes fully.
- i_rst pulsed mid-packet → all outputs 0 immediately (async); after release, src0 wins the first tie.

Source files
------------

// File: rtl/phy_tx_arb_pkg.sv
// Shared encodings and helpers for the PHY TX packet arbiter.
// The state encoding is kept as plain constants so legacy tooling can read it.
package phy_tx_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t XFER  = 2'd1;
  localparam state_t DRAIN = 2'd2;

  localparam int SRC_USER = 0;
  localparam int SRC_CTRL = 1;

  // Wide enough to hold max_beats itself, so the counter never wraps.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/phy_tx_axis_reg.sv
// One-deep AXI-stream output register: loads whenever empty or being drained,
// holds its payload while the downstream stalls.
module phy_tx_axis_reg #(
  parameter int P_DATA_W = 32,
  parameter int P_KEEP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  input  logic [P_DATA_W-1:0] load_data,
  input  logic [P_KEEP_W-1:0] load_keep,
  input  logic                load_last,
  output logic                can_load,
  output logic                m_valid,
  output logic [P_DATA_W-1:0] m_data,
  output logic [P_KEEP_W-1:0] m_keep,
  output logic                m_last,
  input  logic                m_ready
);

  assign can_load = ~m_valid | m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (load_valid && can_load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_keep  <= load_keep;
      m_last  <= load_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/phy_tx_arbiter.sv
// Packet-level round-robin arbiter between user data (source 0) and link/control
// messages (source 1) feeding the PHY TX; truncates and drains over-long packets.
module phy_tx_arbiter
  import phy_tx_arb_pkg::*;
#(
  parameter int P_DATA_W    = 32,
  parameter int P_KEEP_W    = 4,
  parameter int P_MAX_BEATS = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_gt_tx_done,
  input  logic                i_axi_s0_valid,
  input  logic [P_KEEP_W-1:0] i_axi_s0_keep,
  input  logic [P_DATA_W-1:0] i_axi_s0_data,
  input  logic                i_axi_s0_last,
  output logic                o_axi_s0_ready,
  input  logic                i_axi_s1_valid,
  input  logic [P_KEEP_W-1:0] i_axi_s1_keep,
  input  logic [P_DATA_W-1:0] i_axi_s1_data,
  input  logic                i_axi_s1_last,
  output logic                o_axi_s1_ready,
  output logic                o_axi_m_valid,
  output logic [P_KEEP_W-1:0] o_axi_m_keep,
  output logic [P_DATA_W-1:0] o_axi_m_data,
  output logic                o_axi_m_last,
  input  logic                i_axi_m_ready,
  output logic [1:0]          o_grant,
  output logic                o_err_overlong
);

  localparam int CNT_W = cnt_width(P_MAX_BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(P_MAX_BEATS - 1);

  state_t             state;
  logic [1:0]         grant;
  logic               last_srv;
  logic [CNT_W-1:0]   beat_cnt;
  logic               err;

  logic               can_load;
  logic               own_ctrl;
  logic               sel_valid;
  logic               sel_last;
  logic [P_DATA_W-1:0] sel_data;
  logic [P_KEEP_W-1:0] sel_keep;
  logic               xfer_acc;
  logic               drain_acc;
  logic               at_limit;
  logic               pick_ctrl;

  assign own_ctrl = grant[SRC_CTRL];

  always_comb begin
    sel_valid = i_axi_s0_valid;
    sel_last  = i_axi_s0_last;
    sel_data  = i_axi_s0_data;
    sel_keep  = i_axi_s0_keep;
    if (own_ctrl) begin
      sel_valid = i_axi_s1_valid;
      sel_last  = i_axi_s1_last;
      sel_data  = i_axi_s1_data;
      sel_keep  = i_axi_s1_keep;
    end
  end

  assign xfer_acc  = (state == XFER) && sel_valid && can_load;
  assign drain_acc = (state == DRAIN) && sel_valid;
  assign at_limit  = (beat_cnt == LAST_IDX);

  // On a tie the source that was not served last wins.
  assign pick_ctrl = i_axi_s1_valid & (~i_axi_s0_valid | ~last_srv);

  // grant is zero in IDLE, so neither source sees ready there.
  assign o_axi_s0_ready = grant[SRC_USER] & (((state == XFER) & can_load) | (state == DRAIN));
  assign o_axi_s1_ready = grant[SRC_CTRL] & (((state == XFER) & can_load) | (state == DRAIN));

  assign o_grant        = grant;
  assign o_err_overlong = err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      grant    <= 2'b00;
      last_srv <= 1'b1;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_gt_tx_done && (i_axi_s0_valid || i_axi_s1_valid)) begin
            grant <= pick_ctrl ? 2'b10 : 2'b01;
            state <= XFER;
          end
        end
        XFER: begin
          if (xfer_acc) begin
            if (sel_last) begin
              state    <= IDLE;
              grant    <= 2'b00;
              last_srv <= own_ctrl;
              beat_cnt <= '0;
            end else if (at_limit) begin
              state    <= DRAIN;
              err      <= 1'b1;
              beat_cnt <= beat_cnt + CNT_W'(1);
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_acc && sel_last) begin
            state    <= IDLE;
            grant    <= 2'b00;
            last_srv <= own_ctrl;
            beat_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  phy_tx_axis_reg #(
    .P_DATA_W(P_DATA_W),
    .P_KEEP_W(P_KEEP_W)
  ) u_out_reg (
    .clk       (i_clk),
    .rst       (i_rst),
    .load_valid(xfer_acc),
    .load_data (sel_data),
    .load_keep (sel_keep),
    .load_last (sel_last | at_limit),
    .can_load  (can_load),
    .m_valid   (o_axi_m_valid),
    .m_data    (o_axi_m_data),
    .m_keep    (o_axi_m_keep),
    .m_last    (o_axi_m_last),
    .m_ready   (i_axi_m_ready)
  );

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Scoreboard bench for phy_tx_arbiter: accepted source beats become expected
// output beats via a packet-level model (truncation, round-robin order).
module tb_phy_tx_arbiter;

  localparam int DW   = 32;
  localparam int KW   = 4;
  localparam int MAXB = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_gt_tx_done = 1'b0;
  logic          i_axi_s0_valid = 1'b0, i_axi_s1_valid = 1'b0;
  logic [KW-1:0] i_axi_s0_keep = '0, i_axi_s1_keep = '0;
  logic [DW-1:0] i_axi_s0_data = '0, i_axi_s1_data = '0;
  logic          i_axi_s0_last = 1'b0, i_axi_s1_last = 1'b0;
  logic          o_axi_s0_ready, o_axi_s1_ready;
  logic          o_axi_m_valid;
  logic [KW-1:0] o_axi_m_keep;
  logic [DW-1:0] o_axi_m_data;
  logic          o_axi_m_last;
  logic          i_axi_m_ready;
  logic [1:0]    o_grant;
  logic          o_err_overlong;

  phy_tx_arbiter #(.P_DATA_W(DW), .P_KEEP_W(KW), .P_MAX_BEATS(MAXB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_gt_tx_done(i_gt_tx_done),
    .i_axi_s0_valid(i_axi_s0_valid), .i_axi_s0_keep(i_axi_s0_keep),
    .i_axi_s0_data(i_axi_s0_data), .i_axi_s0_last(i_axi_s0_last),
    .o_axi_s0_ready(o_axi_s0_ready),
    .i_axi_s1_valid(i_axi_s1_valid), .i_axi_s1_keep(i_axi_s1_keep),
    .i_axi_s1_data(i_axi_s1_data), .i_axi_s1_last(i_axi_s1_last),
    .o_axi_s1_ready(o_axi_s1_ready),
    .o_axi_m_valid(o_axi_m_valid), .o_axi_m_keep(o_axi_m_keep),
    .o_axi_m_data(o_axi_m_data), .o_axi_m_last(o_axi_m_last),
    .i_axi_m_ready(i_axi_m_ready),
    .o_grant(o_grant), .o_err_overlong(o_err_overlong)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            gap;
  } beat_t;

  beat_t sq0[$], sq1[$], exp_q[$];
  int    pkt_log[$];
  int    total = 0, bad = 0;
  int    cyc = 0, exp_err = 0, err_seen = 0, beats_out = 0;
  int    bidx[2] = '{0, 0};
  int    last_served = 1;
  int    must_next = -1;
  bit    mon_en = 1'b1, gap_chk = 1'b0, blk_chk = 1'b0, prev_end_valid = 1'b0;
  int    ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic rdy(input int src);
    return (src == 0) ? o_axi_s0_ready : o_axi_s1_ready;
  endfunction

  // Packet-level reference: the first MAXB beats of each packet are forwarded,
  // beat MAXB of an unterminated packet is marked last and counts as an error.
  task automatic accept(input int src, input beat_t b);
    beat_t e;
    logic  other_valid;
    other_valid = (src == 0) ? i_axi_s1_valid : i_axi_s0_valid;
    bidx[src]++;
    if (bidx[src] == 1) begin
      pkt_log.push_back(src);
      if (must_next >= 0) check("rr_order", src, must_next);
      must_next = -1;
    end
    if (bidx[src] <= MAXB) begin
      e = b;
      if (bidx[src] == MAXB && !b.last) begin
        e.last = 1'b1;
        exp_err++;
      end
      exp_q.push_back(e);
    end
    if (b.last) begin
      bidx[src]   = 0;
      last_served = src;
      must_next   = other_valid ? 1 - src : -1;
    end
  endtask

  task automatic drive(input int src, input logic v, input beat_t b);
    if (src == 0) begin
      i_axi_s0_valid = v; i_axi_s0_data = b.data; i_axi_s0_keep = b.keep; i_axi_s0_last = b.last;
    end else begin
      i_axi_s1_valid = v; i_axi_s1_data = b.data; i_axi_s1_keep = b.keep; i_axi_s1_last = b.last;
    end
  endtask

  task automatic push_beat(input int src, input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input int gap);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.gap = gap;
    if (src == 0) sq0.push_back(b);
    else sq1.push_back(b);
  endtask

  task automatic run_src(input int src);
    beat_t b;
    int    n, left;
    logic  ok;
    while (1) begin
      if (src == 0) begin
        if (sq0.size() == 0) break;
        b = sq0.pop_front();
      end else begin
        if (sq1.size() == 0) break;
        b = sq1.pop_front();
      end
      drive(src, 1'b1, b);
      n = 0; ok = 1'b0;
      while (!ok && n < 3000) begin
        @(negedge i_clk);
        n++;
        ok = rdy(src);
      end
      if (!ok) begin
        total++; bad++;
        $display("FAIL src%0d_accept_timeout: ready stayed 0, want 1 within 3000 cycles", src);
        drive(src, 1'b0, b);
        if (src == 0) sq0.delete(); else sq1.delete();
        break;
      end
      accept(src, b);
      @(posedge i_clk); #1;
      left = (src == 0) ? sq0.size() : sq1.size();
      if (b.gap > 0 || left == 0) begin
        drive(src, 1'b0, b);
        repeat (b.gap) begin @(posedge i_clk); #1; end
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge i_clk); n++; end
    repeat (3) @(posedge i_clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial forever begin @(posedge i_clk); cyc++; end

  initial begin
    i_axi_m_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      case (ready_mode)
        1:       i_axi_m_ready = ($urandom_range(0, 3) != 0);
        2:       i_axi_m_ready = ~i_axi_m_ready;
        default: i_axi_m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every downstream transfer.
  initial begin
    beat_t         e;
    logic          have_blk = 1'b0;
    logic [DW+KW:0] prev_beat = '0;
    logic          first_of_pkt = 1'b1;
    int            end_cyc = 0;
    forever begin
      @(negedge i_clk);
      if (!mon_en) begin
        have_blk = 1'b0;
        first_of_pkt = 1'b1;
      end else begin
        if (have_blk) begin
          check("hold_valid", o_axi_m_valid, 1'b1);
          check("hold_beat", {o_axi_m_data, o_axi_m_keep, o_axi_m_last}, prev_beat);
        end
        have_blk  = o_axi_m_valid & ~i_axi_m_ready;
        prev_beat = {o_axi_m_data, o_axi_m_keep, o_axi_m_last};
        if (o_axi_m_valid && i_axi_m_ready) begin
          beats_out++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat: got data %0h, want no beat", o_axi_m_data);
          end else begin
            e = exp_q.pop_front();
            check("beat", {o_axi_m_data, o_axi_m_keep, o_axi_m_last}, {e.data, e.keep, e.last});
          end
          if (gap_chk && prev_end_valid && first_of_pkt) check("pkt_gap", cyc - end_cyc, 2);
          first_of_pkt = o_axi_m_last;
          if (o_axi_m_last) begin
            end_cyc = cyc;
            prev_end_valid = 1'b1;
          end
        end
        if (o_err_overlong) err_seen++;
        check("ready_exclusive", o_axi_s0_ready & o_axi_s1_ready, 1'b0);
        if (blk_chk && o_axi_m_valid && !i_axi_m_ready)
          check("ready_when_blocked", o_axi_s0_ready | o_axi_s1_ready, 1'b0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ls, es, bo, first_exp;
    beat_t z;
    z.data = '0; z.keep = '0; z.last = 1'b0; z.gap = 0;

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_m_valid", o_axi_m_valid, 1'b0);
    check("rst_grant", o_grant, 2'b00);
    check("rst_s0_ready", o_axi_s0_ready, 1'b0);
    check("rst_s1_ready", o_axi_s1_ready, 1'b0);
    check("rst_err", o_err_overlong, 1'b0);
    i_rst = 1'b0;
    i_gt_tx_done = 1'b1;
    @(posedge i_clk); #1;

    // Directed 3-beat packet from source 0
    push_beat(0, 32'h12345678, 4'b1111, 1'b0, 0);
    push_beat(0, 32'h87654321, 4'b1111, 1'b0, 0);
    push_beat(0, 32'h98765432, 4'b1000, 1'b1, 0);
    lat = 0;
    fork
      run_src(0);
      begin
        while (!o_axi_m_valid && lat < 20) begin @(posedge i_clk); #2; lat++; end
        check("first_beat_latency", lat, 2);
        check("grant_during_pkt", o_grant, 2'b01);
      end
    join
    wait_drain();

    // Both sources contending: packets must alternate with one idle cycle between
    gap_chk = 1'b1; prev_end_valid = 1'b0;
    ls = pkt_log.size();
    first_exp = 1 - last_served;
    for (int p = 0; p < 3; p++) begin
      push_beat(0, 32'hA000_0000 + p * 2, 4'hF, 1'b0, 0);
      push_beat(0, 32'hA000_0001 + p * 2, 4'hF, 1'b1, 0);
      push_beat(1, 32'hB000_0000 + p * 2, 4'hF, 1'b0, 0);
      push_beat(1, 32'hB000_0001 + p * 2, 4'hF, 1'b1, 0);
    end
    fork
      run_src(0);
      run_src(1);
    join
    wait_drain();
    gap_chk = 1'b0;
    check("alt_count", pkt_log.size() - ls, 6);
    for (int k = 0; k < 6; k++) check("alt_order", pkt_log[ls + k], (first_exp + k) % 2);

    // Over-long packet: 6 beats against a 4-beat limit
    es = err_seen; bo = beats_out;
    for (int k = 1; k <= 6; k++) push_beat(1, k, 4'hF, k == 6, 0);
    run_src(1);
    wait_drain();
    check("overlong_pulse_count", err_seen - es, 1);
    check("overlong_beats_out", beats_out - bo, 4);
    check("idle_after_drain", o_grant, 2'b00);

    // Exactly MAXB beats terminated by last is legal
    es = err_seen; bo = beats_out;
    for (int k = 1; k <= MAXB; k++) push_beat(0, 32'hC0 + k, 4'hF, k == MAXB, 0);
    run_src(0);
    wait_drain();
    check("exact_max_no_err", err_seen - es, 0);
    check("exact_max_beats_out", beats_out - bo, MAXB);

    // Downstream ready toggling during a 4-beat packet
    ready_mode = 2; blk_chk = 1'b1;
    for (int k = 0; k < 4; k++) push_beat(0, $urandom, 4'($urandom_range(1, 15)), k == 3, 0);
    run_src(0);
    wait_drain();
    ready_mode = 0; blk_chk = 1'b0;

    // GT not done: no grant until it rises; dropping it mid-packet is harmless
    i_gt_tx_done = 1'b0;
    bo = beats_out;
    for (int k = 0; k < 4; k++) push_beat(0, 32'hD0 + k, 4'hF, k == 3, 0);
    fork
      run_src(0);
      begin
        repeat (5) @(posedge i_clk);
        #2;
        check("no_grant_gt_low", o_grant, 2'b00);
        check("no_ready_gt_low", o_axi_s0_ready, 1'b0);
        i_gt_tx_done = 1'b1;
        @(posedge i_clk); #2;
        check("grant_after_gt", o_grant, 2'b01);
        i_gt_tx_done = 1'b0;
      end
    join
    wait_drain();
    check("gt_drop_pkt_complete", beats_out - bo, 4);
    i_gt_tx_done = 1'b1;

    // Randomized traffic
    ready_mode = 1;
    for (int p = 0; p < 30; p++) begin
      for (int s = 0; s < 2; s++) begin
        int len, gap;
        len = $urandom_range(1, 6);
        gap = $urandom_range(0, 3);
        for (int k = 0; k < len; k++)
          push_beat(s, $urandom, 4'($urandom_range(1, 15)), k == len - 1, (k == len - 1) ? gap : 0);
      end
    end
    fork
      run_src(0);
      run_src(1);
      begin
        for (int k = 0; k < 80; k++) begin
          @(posedge i_clk); #1;
          i_gt_tx_done = ($urandom_range(0, 4) != 0);
        end
        i_gt_tx_done = 1'b1;
      end
    join
    ready_mode = 0;
    wait_drain();

    // Asynchronous reset mid-packet
    mon_en = 1'b0;
    @(posedge i_clk); #1;
    i_axi_s0_valid = 1'b1; i_axi_s0_data = 32'hA5A5A5A5; i_axi_s0_keep = 4'hF; i_axi_s0_last = 1'b0;
    lat = 0;
    while (!o_axi_m_valid && lat < 10) begin @(posedge i_clk); #1; lat++; end
    check("pre_reset_beat_out", o_axi_m_valid, 1'b1);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_m_valid", o_axi_m_valid, 1'b0);
    check("async_rst_m_data", {o_axi_m_data, o_axi_m_keep, o_axi_m_last}, '0);
    check("async_rst_grant", o_grant, 2'b00);
    check("async_rst_readies", {o_axi_s0_ready, o_axi_s1_ready, o_err_overlong}, 3'b000);
    drive(0, 1'b0, z);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    exp_q.delete();
    bidx[0] = 0; bidx[1] = 0;
    last_served = 1; must_next = -1;
    @(posedge i_clk); #1;
    mon_en = 1'b1;
    ls = pkt_log.size();
    push_beat(0, 32'hE0, 4'hF, 1'b1, 0);
    push_beat(1, 32'hE1, 4'hF, 1'b1, 0);
    fork
      run_src(0);
      run_src(1);
    join
    wait_drain();
    check("tie_after_reset_first", pkt_log[ls], 0);
    check("tie_after_reset_second", pkt_log[ls + 1], 1);

    check("err_total", err_seen, exp_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
